// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_regfile
//  Description : APB completer with a small 32-bit register bank. It holds
//                six R/W registers, a committed-write counter and a constant
//                ID register. Each access waits a programmable number of
//                cycles, and the read data, Pready and Pslverr outputs are
//                all registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int          SLAVE_ID    = 0,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam logic [1:0] c_SEL_IDX   = 2'(SLAVE_ID);
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);
    localparam int         c_NUM_RW    = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic [31:0] r_regs [c_NUM_RW];
    logic [15:0] r_wrcnt;

    logic [31:0] r_prdata;
    logic        r_pready;
    logic        r_pslverr;

    logic        w_sel;
    logic [7:0]  w_off;
    logic        w_err;
    logic        w_commit;
    logic        w_enter_access;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel = Pselx[c_SEL_IDX];
    assign w_off = Paddr[7:0];

    // Only the low address byte and our own select bit take part in decode.
    assign w_unused = ^{Paddr[31:8], Pselx};

    // Misaligned, beyond the map, or a write to one of the two read-only words.
    assign w_err = (w_off[1:0] != 2'b00)
                 | (w_off[7:5] != 3'b000)
                 | (Pwrite & (w_off[4:3] == 2'b11));

    // Writes land on the edge that closes the ACCESS cycle; a dropped select
    // or an erroring transfer leaves every register untouched.
    assign w_commit = (r_state == S_ACCESS) & w_sel & Penable & Pwrite & ~w_err;

    assign w_enter_access = (w_state_next == S_ACCESS);

    // Next-state and wait-counter logic of the transfer sequencer.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                // Penable already high here is a protocol violation: ignore it.
                if (w_sel && !Penable) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = S_ACCESS;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = c_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!w_sel) begin
                    // Master abandoned the transfer.
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_next = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Read multiplexer over the whole 8-word map.
    always_comb begin
        w_rdata = 32'd0;
        case (w_off[4:2])
            3'd0:    w_rdata = r_regs[0];
            3'd1:    w_rdata = r_regs[1];
            3'd2:    w_rdata = r_regs[2];
            3'd3:    w_rdata = r_regs[3];
            3'd4:    w_rdata = r_regs[4];
            3'd5:    w_rdata = r_regs[5];
            3'd6:    w_rdata = {16'd0, r_wrcnt};
            default: w_rdata = ID_VALUE;
        endcase
    end

    // Response registers: loaded on the edge entering ACCESS so they are valid
    // for exactly the Pready cycle and return to zero afterwards. Read data is
    // only presented for error-free reads.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_prdata  <= 32'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready  <= w_enter_access;
            r_pslverr <= w_enter_access & w_err;
            r_prdata  <= (w_enter_access && !w_err && !Pwrite) ? w_rdata : 32'd0;
        end
    end

    // Read/write register bank, one storage word per generate iteration.
    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_RW; gi++) begin : g_rw_reg
            // Capture the ACCESS-edge write data when this word is addressed.
            always_ff @(posedge Hclk) begin
                if (Hreset) begin
                    r_regs[gi] <= 32'd0;
                end else if (w_commit && (w_off[4:2] == 3'(gi))) begin
                    r_regs[gi] <= Pwdata;
                end
            end
        end
    endgenerate

    // Committed-write counter; natural 16-bit wrap.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_wrcnt <= 16'd0;
        end else if (w_commit) begin
            r_wrcnt <= r_wrcnt + 16'd1;
        end
    end

    assign Prdata  = r_prdata;
    assign Pready  = r_pready;
    assign Pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) peripheral that answers the bridge's APB master outputs (Pselx, Penable, Pwrite, Paddr, Pwdata). It decodes one bit of the one-hot Pselx bus and holds a small 32-bit register bank. It inserts a programmable number of wait states and returns Prdata, Pready and Pslverr. One instance is placed per Pselx bit behind the AHB-to-APB bridge.

## Interface
- SLAVE_ID, 0: index of the Pselx bit this instance responds to (0..2).
- WAIT_STATES, 1: Pready-low cycles in the access phase (0..15).
- ID_VALUE, 32'hA5B0_0001: constant returned by register 7.
- Hclk  in  1  clock; all logic on rising edge.
- Hreset  in  1  reset; synchronous, active-high.
- Pselx  in  3  one-hot slave select; only Pselx[SLAVE_ID] is used.
- Penable  in  1  access-phase indicator.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address; only Paddr[7:0] is decoded.
- Pwdata  in  32  write data.
- Prdata  out  32  read data, registered.
- Pready  out  1  transfer-complete, registered.
- Pslverr  out  1  error response, registered.

## Operation
- sel = Pselx[SLAVE_ID].
- Register map (offset = Paddr[7:0]):
  - 0x00–0x14: six R/W registers, reset 0.
  - 0x18: WRCNT, read-only, 16-bit count of committed writes, zero-extended; wraps 0xFFFF→0x0000.
  - 0x1C: ID, read-only, returns ID_VALUE.
- An access is an error when any of the following holds:
  - Paddr[1:0] != 0;
  - offset >= 0x20;
  - it is a write to 0x18 or 0x1C.
- On error: no register changes, WRCNT is not incremented, Prdata = 0.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: if sel & ~Penable (setup phase), go to ACCESS when WAIT_STATES == 0, else go to WAIT with cnt = WAIT_STATES.
  - WAIT: Pready = 0. If ~sel, go to IDLE (aborted transfer). Else decrement cnt; when cnt == 1, go to ACCESS.
  - ACCESS: Pready = 1 for exactly one cycle, then go to IDLE unconditionally.
- Write commit:
  - Happens on the edge that ends ACCESS, if sel & Penable & Pwrite & no error.
  - Commits Pwdata to the addressed register and increments WRCNT on the same edge.
  - If sel has dropped at that edge: no commit.
- Read data:
  - Captured on the edge entering ACCESS, from Paddr held by the master.
  - Presented in the ACCESS cycle.
  - Prdata = 0 in every non-ACCESS cycle and for error reads.
- Pslverr is 1 only in an ACCESS cycle of an erroring transfer; 0 at all other times.
- Pselx bits other than SLAVE_ID are ignored. Transfers to other slaves leave all state and outputs at idle values.

## Timing
- Reset (Hreset = 1 at an edge) forces the following on that edge, including mid-transfer:
  - state IDLE, cnt 0;
  - Prdata 0, Pready 0, Pslverr 0;
  - R/W registers 0, WRCNT 0.
- An aborted transfer commits nothing.
- Latency: setup cycle T0, then WAIT_STATES cycles with Pready = 0, then Pready = 1 in cycle T0+1+WAIT_STATES. Total transfer = 2 + WAIT_STATES cycles.
- Back-to-back transfers:
  - A new setup phase may start in the cycle immediately after ACCESS (sampled in IDLE). No idle cycle is required.
  - Throughput is one transfer per 2 + WAIT_STATES cycles.
- Protocol violations:
  - Penable high while in IDLE: ignored, no transfer starts.
  - sel dropping during WAIT: abort to IDLE next cycle.
- Address and write data must be stable from setup through ACCESS (master's responsibility). Only the ACCESS-edge sample of Pwdata is used.
- Simultaneous write commit and WRCNT read are impossible, since there is one transfer at a time.

## Test plan
- Reset with WAIT_STATES = 1: assert Hreset mid-WAIT → next cycle Prdata = 0, Pready = 0, Pslverr = 0. A following read of 0x18 returns 0 and a read of 0x00 returns 0.
- Write then read, WAIT_STATES = 1:
  - Write 0x0000_BEEF to 0x04 → Pready high exactly 2 cycles after the setup cycle, Pslverr = 0.
  - Read 0x04 → Prdata = 0x0000_BEEF in the Pready cycle.
  - Read 0x18 → 0x0000_0001.
- Zero wait, back-to-back, WAIT_STATES = 0: writes to 0x00, 0x08, 0x10 in consecutive 2-cycle transfers → Pready high every second cycle, all three values read back, WRCNT = 3.
- Errors:
  - Write to 0x1C → Pslverr = 1 with Pready; ID still reads 32'hA5B0_0001.
  - Read 0x20 → Pslverr = 1, Prdata = 0.
  - Write to 0x02 → Pslverr = 1, no register change.
  - WRCNT unchanged after all three.
- Abort and other slave, WAIT_STATES = 3:
  - Drop sel during WAIT on a write to 0x00 → no Pready, register 0x00 unchanged.
  - A transfer with Pselx selecting a different bit → Pready stays 0.
- Wrap: 65536 valid writes → WRCNT reads 0x0000_0000; one more write → 0x0000_0001.
